// File: rtl/ttt_pkg.sv
// Shared encodings and helpers for the tic-tac-toe turn controller.
package ttt_pkg;

    typedef enum logic [1:0] {
        S_HUMAN = 2'd0,
        S_BOT   = 2'd1,
        S_CHECK = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int         CELLS     = 9;
    localparam logic [3:0] MAX_MOVES = 4'd9;

    // True when exactly one cell bit is set.
    function automatic logic is_onehot(input logic [CELLS-1:0] v);
        return (v != '0) && ((v & (v - CELLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/first_empty.sv
// Picks the lowest-index free cell as a one-hot vector (zero when the board is full).
module first_empty
    import ttt_pkg::*;
(
    input  logic [CELLS-1:0] free,
    output logic [CELLS-1:0] sel
);

    // Two's-complement isolate-lowest-set-bit.
    assign sel = free & (~free + CELLS'(1));

endmodule

// File: rtl/win_condition.sv
// Flags any completed line (3 rows, 3 columns, 2 diagonals) on one player's board.
module win_condition
    import ttt_pkg::*;
(
    input  logic [CELLS-1:0] board,
    output logic             win
);

    assign win = (&board[2:0]) | (&board[5:3]) | (&board[8:6])
               | (board[0] & board[3] & board[6])
               | (board[1] & board[4] & board[7])
               | (board[2] & board[5] & board[8])
               | (board[0] & board[4] & board[8])
               | (board[2] & board[4] & board[6]);

endmodule

// File: rtl/game_sequencer.sv
// Registered turn controller: owns both occupancy boards, accepts one legal move
// per turn, commits the bot suggestion after a settle delay and latches game over.
module game_sequencer
    import ttt_pkg::*;
#(
    parameter bit BOT_FIRST = 1'b0,
    parameter int BOT_DELAY = 2
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             new_game,
    input  logic             mv_valid,
    input  logic [CELLS-1:0] mv_cell,
    input  logic [CELLS-1:0] bot_cell,
    output logic [CELLS-1:0] red_q,
    output logic [CELLS-1:0] green_q,
    output logic             rt,
    output logic             gt,
    output logic             rw,
    output logic             gw,
    output logic             draw,
    output logic             err,
    output logic [3:0]       move_cnt
);

    localparam state_t     ST_START = BOT_FIRST ? S_BOT : S_HUMAN;
    localparam logic [3:0] DLY_LAST = 4'(BOT_DELAY - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       dly_q, dly_d;
    logic [CELLS-1:0] red_d, green_d;
    logic [3:0]       cnt_d;
    logic             rw_d, gw_d, draw_d, err_d;

    logic [CELLS-1:0] occ, free, fb_cell, bot_pick;
    logic             red_line, green_line, mv_legal, bot_ok;

    assign occ  = red_q | green_q;
    assign free = ~occ;

    first_empty u_first_empty (
        .free (free),
        .sel  (fb_cell)
    );

    win_condition u_red_win (
        .board (red_q),
        .win   (red_line)
    );

    win_condition u_green_win (
        .board (green_q),
        .win   (green_line)
    );

    assign mv_legal = is_onehot(mv_cell) && ((occ & mv_cell) == '0);
    assign bot_ok   = is_onehot(bot_cell) && ((occ & bot_cell) == '0);
    // A zero, multi-hot or occupied suggestion falls back to the lowest free cell.
    assign bot_pick = bot_ok ? bot_cell : fb_cell;

    assign rt = (state_q == S_HUMAN);
    assign gt = (state_q == S_BOT);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dly_d   = 4'd0;
        red_d   = red_q;
        green_d = green_q;
        cnt_d   = move_cnt;
        rw_d    = rw;
        gw_d    = gw;
        draw_d  = draw;
        err_d   = 1'b0;

        if (new_game) begin
            state_d = ST_START;
            last_d  = 1'b0;
            red_d   = '0;
            green_d = '0;
            cnt_d   = 4'd0;
            rw_d    = 1'b0;
            gw_d    = 1'b0;
            draw_d  = 1'b0;
        end else begin
            case (state_q)
                S_HUMAN: begin
                    if (mv_valid) begin
                        if (mv_legal) begin
                            red_d   = red_q | mv_cell;
                            cnt_d   = move_cnt + 4'd1;
                            last_d  = 1'b0;
                            state_d = S_CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                S_BOT: begin
                    // dly_q is zero on entry, so the commit lands BOT_DELAY edges later.
                    if (dly_q == DLY_LAST) begin
                        green_d = green_q | bot_pick;
                        cnt_d   = move_cnt + 4'd1;
                        last_d  = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        dly_d = dly_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (red_line) begin
                        rw_d    = 1'b1;
                        state_d = S_OVER;
                    end else if (green_line) begin
                        gw_d    = 1'b1;
                        state_d = S_OVER;
                    end else if (move_cnt == MAX_MOVES) begin
                        draw_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        state_d = last_q ? S_HUMAN : S_BOT;
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = ST_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q  <= ST_START;
            last_q   <= 1'b0;
            dly_q    <= 4'd0;
            red_q    <= '0;
            green_q  <= '0;
            move_cnt <= 4'd0;
            rw       <= 1'b0;
            gw       <= 1'b0;
            draw     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            dly_q    <= dly_d;
            red_q    <= red_d;
            green_q  <= green_d;
            move_cnt <= cnt_d;
            rw       <= rw_d;
            gw       <= gw_d;
            draw     <= draw_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: table of scripted turns with a scoreboard
// queue, plus hand-written latency, reset and restart sequences.
module tb_game_sequencer;
    import ttt_pkg::*;

    localparam int BOT_DELAY = 2;
    localparam int NSTEPS    = 18;

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic       new_game = 1'b0;
    logic       mv_valid = 1'b0;
    logic [8:0] mv_cell = '0;
    logic [8:0] bot_cell = '0;
    logic [8:0] red_q, green_q;
    logic       rt, gt, rw, gw, draw, err;
    logic [3:0] move_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       ng;
        logic [8:0] mv;
        logic [8:0] bot;
        logic [8:0] red;
        logic [8:0] green;
        logic [3:0] cnt;
        logic       err;
        logic [2:0] over;
    } step_t;

    step_t steps[NSTEPS];
    step_t sbq[$];

    game_sequencer #(
        .BOT_FIRST (1'b0),
        .BOT_DELAY (BOT_DELAY)
    ) dut (
        .clk      (clk),
        .rs       (rs),
        .new_game (new_game),
        .mv_valid (mv_valid),
        .mv_cell  (mv_cell),
        .bot_cell (bot_cell),
        .red_q    (red_q),
        .green_q  (green_q),
        .rt       (rt),
        .gt       (gt),
        .rw       (rw),
        .gw       (gw),
        .draw     (draw),
        .err      (err),
        .move_cnt (move_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic step_t mk(input logic ng, input logic [8:0] mv, input logic [8:0] bot,
                                 input logic [8:0] red, input logic [8:0] green,
                                 input logic [3:0] cnt, input logic e, input logic [2:0] over);
        step_t s;
        s.ng = ng; s.mv = mv; s.bot = bot; s.red = red; s.green = green;
        s.cnt = cnt; s.err = e; s.over = over;
        return s;
    endfunction

    task automatic run_step(input step_t s, input int idx);
        step_t      e;
        logic       err_seen;
        logic [8:0] r_hold;
        int         waited;
        if (s.ng) begin
            new_game = 1'b1;
            tick();
            new_game = 1'b0;
        end
        sbq.push_back(s);
        bot_cell = s.bot;
        mv_cell  = s.mv;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        mv_cell  = '0;
        @(negedge clk);
        err_seen = err;
        if (s.err) begin
            @(negedge clk);
            chk($sformatf("s%0d_err_one_cycle", idx), 32'(err), 32'(0));
        end
        waited = 0;
        while (!(rt || rw || gw || draw) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("s%0d_settled", idx), 32'(waited < 40), 32'(1));
        e = sbq.pop_front();
        chk($sformatf("s%0d_red", idx), 32'(red_q), 32'(e.red));
        chk($sformatf("s%0d_green", idx), 32'(green_q), 32'(e.green));
        chk($sformatf("s%0d_cnt", idx), 32'(move_cnt), 32'(e.cnt));
        chk($sformatf("s%0d_err", idx), 32'(err_seen), 32'(e.err));
        chk($sformatf("s%0d_rw_gw_draw", idx), 32'({rw, gw, draw}), 32'(e.over));
        chk($sformatf("s%0d_disjoint", idx), 32'(red_q & green_q), 32'(0));
        chk($sformatf("s%0d_popcount", idx), 32'($countones(red_q | green_q)), 32'(move_cnt));
        if (e.over != 3'b000) begin
            chk($sformatf("s%0d_over_lights", idx), 32'({rt, gt}), 32'(0));
            r_hold   = red_q;
            mv_cell  = 9'h008;
            mv_valid = 1'b1;
            tick();
            mv_valid = 1'b0;
            mv_cell  = '0;
            @(negedge clk);
            chk($sformatf("s%0d_over_ignore_red", idx), 32'(red_q), 32'(r_hold));
            chk($sformatf("s%0d_over_ignore_err", idx), 32'(err), 32'(0));
            chk($sformatf("s%0d_over_hold", idx), 32'({rw, gw, draw}), 32'(e.over));
        end
    endtask

    initial begin
        // Fallback, error pulses and a green win on the bot's fallback move.
        steps[0]  = mk(1'b1, 9'h010, 9'h001, 9'h010, 9'h001, 4'd2, 1'b0, 3'b000);
        steps[1]  = mk(1'b0, 9'h010, 9'h000, 9'h010, 9'h001, 4'd2, 1'b1, 3'b000);
        steps[2]  = mk(1'b0, 9'h003, 9'h000, 9'h010, 9'h001, 4'd2, 1'b1, 3'b000);
        steps[3]  = mk(1'b0, 9'h100, 9'h000, 9'h110, 9'h003, 4'd4, 1'b0, 3'b000);
        steps[4]  = mk(1'b0, 9'h040, 9'h0C0, 9'h150, 9'h007, 4'd6, 1'b0, 3'b010);
        // Red wins on cells 1,2,3 against bot cells 5 and 9.
        steps[5]  = mk(1'b1, 9'h001, 9'h010, 9'h001, 9'h010, 4'd2, 1'b0, 3'b000);
        steps[6]  = mk(1'b0, 9'h002, 9'h100, 9'h003, 9'h110, 4'd4, 1'b0, 3'b000);
        steps[7]  = mk(1'b0, 9'h004, 9'h000, 9'h007, 9'h110, 4'd5, 1'b0, 3'b100);
        // Full board with no line.
        steps[8]  = mk(1'b1, 9'h010, 9'h000, 9'h010, 9'h001, 4'd2, 1'b0, 3'b000);
        steps[9]  = mk(1'b0, 9'h100, 9'h004, 9'h110, 9'h005, 4'd4, 1'b0, 3'b000);
        steps[10] = mk(1'b0, 9'h002, 9'h020, 9'h112, 9'h025, 4'd6, 1'b0, 3'b000);
        steps[11] = mk(1'b0, 9'h008, 9'h080, 9'h11A, 9'h0A5, 4'd8, 1'b0, 3'b000);
        steps[12] = mk(1'b0, 9'h040, 9'h000, 9'h15A, 9'h0A5, 4'd9, 1'b0, 3'b001);
        // Ninth move completes red row 7-8-9: win, not draw.
        steps[13] = mk(1'b1, 9'h001, 9'h010, 9'h001, 9'h010, 4'd2, 1'b0, 3'b000);
        steps[14] = mk(1'b0, 9'h020, 9'h008, 9'h021, 9'h018, 4'd4, 1'b0, 3'b000);
        steps[15] = mk(1'b0, 9'h040, 9'h004, 9'h061, 9'h01C, 4'd6, 1'b0, 3'b000);
        steps[16] = mk(1'b0, 9'h080, 9'h002, 9'h0E1, 9'h01E, 4'd8, 1'b0, 3'b000);
        steps[17] = mk(1'b0, 9'h100, 9'h000, 9'h1E1, 9'h01E, 4'd9, 1'b0, 3'b100);

        #3;
        chk("reset_boards", 32'({red_q, green_q}), 32'(0));
        chk("reset_cnt", 32'(move_cnt), 32'(0));
        chk("reset_flags", 32'({rw, gw, draw, err}), 32'(0));
        chk("reset_lights", 32'({rt, gt}), 32'(2'b10));
        #9;
        rs = 1'b0;
        tick();

        // First-move latency: red 1 cycle, gt 1 cycle later, green BOT_DELAY after gt.
        bot_cell = 9'h001;
        mv_cell  = 9'h010;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        mv_cell  = '0;
        @(negedge clk);
        chk("lat_red", 32'(red_q), 32'(9'h010));
        chk("lat_cnt1", 32'(move_cnt), 32'(1));
        chk("lat_gt_low", 32'({rt, gt}), 32'(0));
        tick();
        @(negedge clk);
        chk("lat_gt_high", 32'(gt), 32'(1));
        for (int i = 1; i < BOT_DELAY; i++) begin
            tick();
            @(negedge clk);
            chk($sformatf("lat_green_wait%0d", i), 32'(green_q), 32'(0));
        end
        tick();
        @(negedge clk);
        chk("lat_green", 32'(green_q), 32'(9'h001));
        chk("lat_cnt2", 32'(move_cnt), 32'(2));

        for (int i = 0; i < NSTEPS; i++) begin
            run_step(steps[i], i);
        end

        // After a win, new_game restarts with the human to move.
        @(negedge clk);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        @(negedge clk);
        chk("ng_clear", 32'({red_q, green_q, move_cnt}), 32'(0));
        chk("ng_flags", 32'({rw, gw, draw}), 32'(0));
        chk("ng_rt", 32'({rt, gt}), 32'(2'b10));

        // Asynchronous reset in the middle of the bot delay.
        mv_cell  = 9'h001;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        mv_cell  = '0;
        tick();
        tick();
        #2;
        chk("mid_bot_gt", 32'(gt), 32'(1));
        rs = 1'b1;
        #1;
        chk("async_boards", 32'({red_q, green_q}), 32'(0));
        chk("async_cnt", 32'(move_cnt), 32'(0));
        chk("async_lights", 32'({rt, gt}), 32'(2'b10));
        chk("async_flags", 32'({rw, gw, draw, err}), 32'(0));
        @(negedge clk);
        rs = 1'b0;
        tick();
        @(negedge clk);
        chk("post_reset_rt", 32'(rt), 32'(1));

        // new_game beats a simultaneous legal human move.
        bot_cell = 9'h000;
        mv_cell  = 9'h100;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        mv_cell  = '0;
        for (int i = 0; i < 40 && !rt; i++) @(negedge clk);
        @(negedge clk);
        chk("pre_ng_board", 32'({red_q, green_q}), 32'({9'h100, 9'h001}));
        new_game = 1'b1;
        mv_cell  = 9'h010;
        mv_valid = 1'b1;
        tick();
        new_game = 1'b0;
        mv_valid = 1'b0;
        mv_cell  = '0;
        @(negedge clk);
        chk("ng_prio_board", 32'({red_q, green_q}), 32'(0));
        chk("ng_prio_cnt", 32'(move_cnt), 32'(0));
        chk("ng_prio_rt", 32'(rt), 32'(1));
        tick();
        @(negedge clk);
        chk("ng_prio_hold", 32'({red_q, green_q, move_cnt}), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Registered turn controller for the autonomous tic-tac-toe board. It owns the red (human) and green (bot) occupancy registers and accepts one-hot human moves. It samples the combinational bot suggestion from computer_input after a settle delay, commits that move, and evaluates win/draw after every move. It replaces the purely combinational overlay in main, giving one legal move per turn, turn lights and a latched game-over state.

Parameters:
BOT_FIRST, 0, 1 = bot (green) moves first after reset/new game
BOT_DELAY, 2, cycles spent in S_BOT before sampling bot_cell (legal range 1..15; settle time for computer_input)

Ports:
clk  input  1  system clock, rising edge
rs  input  1  reset, asynchronous, active-high
new_game  input  1  synchronous single-cycle clear/restart request
mv_valid  input  1  human move strobe, one cycle
mv_cell  input  9  human target cell, one-hot, bit0 = cell1 … bit8 = cell9
bot_cell  input  9  bot suggestion from computer_input (o1..o9), driven from red_q/green_q
red_q  output  9  registered red occupancy (R1..R9)
green_q  output  9  registered green occupancy (G1..G9)
rt  output  1  human-turn light
gt  output  1  bot-turn light
rw  output  1  red win, latched
gw  output  1  green win, latched
draw  output  1  board full with no win, latched
err  output  1  one-cycle pulse: human move rejected
move_cnt  output  4  committed moves, 0..9

Behaviour:
- Reset: rs=1 asynchronously forces red_q=0, green_q=0, move_cnt=0, rw=gw=draw=err=0, and state=S_BOT if BOT_FIRST else S_HUMAN. rt/gt are decoded from state: rt=1 only in S_HUMAN, gt=1 only in S_BOT.
- States: S_HUMAN, S_BOT, S_CHECK, S_OVER. A 1-bit last_mover register records who moved last (0=red, 1=green).
- S_HUMAN:
  - Legal move: mv_valid=1 and mv_cell has exactly one bit set and (red_q|green_q)&mv_cell==0. On the next edge, red_q |= mv_cell, move_cnt+1, last_mover=0, state=S_CHECK.
  - Illegal move (zero or multiple bits, or occupied cell): err=1 for the following cycle only; board unchanged; stay in S_HUMAN.
  - mv_valid=0: hold.
- S_BOT:
  - A 4-bit delay counter clears on entry. On the BOT_DELAY-th rising edge after entry the block samples bot_cell.
  - If bot_cell is one-hot and empty, green_q |= bot_cell.
  - Otherwise green_q |= the lowest-index empty cell (fallback covers a zero or multi-hot suggestion).
  - Then move_cnt+1, last_mover=1, state=S_CHECK.
  - mv_valid in S_BOT is ignored and does not pulse err.
- S_CHECK, one cycle, evaluated on the registered boards:
  - Red has a line (8 lines: 3 rows, 3 columns, 2 diagonals) → rw=1, state=S_OVER.
  - Else green has a line → gw=1, state=S_OVER.
  - Else move_cnt==9 → draw=1, state=S_OVER.
  - Else go to S_BOT if last_mover=0, or S_HUMAN if last_mover=1.
  - A win on the 9th move reports the win, not draw.
- S_OVER: board, move_cnt and rw/gw/draw hold; rt=gt=0; mv_valid ignored; leave only via new_game or rs.
- new_game=1 in any state: synchronous clear, same values as reset, on the next edge. It has priority over a simultaneous mv_valid or bot commit.
- Latency:
  - Human strobe to red_q update: 1 cycle.
  - red_q update to gt=1: 1 cycle (S_CHECK).
  - gt rising to green_q update: BOT_DELAY cycles.
- Invariants: red_q & green_q == 0 always; move_cnt == popcount(red_q|green_q); at most one of rw/gw/draw set.

Decomposition:
- Shared package (ttt_pkg): state encoding S_HUMAN=2'd0, S_BOT=2'd1, S_CHECK=2'd2, S_OVER=2'd3; CELLS=9; MAX_MOVES=4'd9.
- Line detection reuses the existing win_condition module, instantiated twice (red_q, green_q).
- One new sub-module, first_empty: 9-bit free mask in, one-hot lowest-index free cell out, used for the bot fallback.

Test Plan:
- Reset with BOT_FIRST=0, then mv_valid with mv_cell=9'h010 (centre) → next cycle red_q=9'h010, move_cnt=1. One cycle later gt=1. BOT_DELAY=2 cycles after that, green_q equals the bot_cell presented (e.g. 9'h001).
- Repeat mv_cell=9'h010 on human's second turn → err pulses exactly one cycle; red_q unchanged; rt stays 1. Then mv_cell=9'h003 → err pulses, nothing committed.
- Bench drives bot_cell=9'h000, red_q=9'h010 → green_q gets 9'h001 (fallback). With cell1 already taken, fallback gives 9'h002.
- Human plays cells 1, 2, 3 while bot takes 5 and 9 → after S_CHECK rw=1, rt=gt=0. Further mv_valid is ignored; new_game clears everything and rt=1.
- Scripted draw sequence ending with move 9 → draw=1, rw=gw=0, move_cnt=9. A variant where move 9 completes a red line → rw=1, draw=0.
- Assert rs mid-S_BOT (delay counter=1) → all outputs 0 immediately without a clock edge. Deassert → S_HUMAN, rt=1. Also drive new_game together with a legal mv_valid → board stays empty.
